// File: rtl/li_link_if.sv
// li_link valid/stop channel: data and valid travel forward, stop travels back.
// The producer side uses master and the consumer side uses slave.
interface li_link_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             stop;

    modport master (output data, output valid, input stop);
    modport slave  (input data, input valid, output stop);
endinterface

// File: rtl/li_relay_fifo.sv
// DEPTH-entry relay station for li_link with registered forward/backward paths and skid margin.
// Optional statistics outputs (stall_cycles, max_occupancy) when LI_RELAY_FIFO_STATS_EN is defined.
module li_relay_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int SKID  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    li_link_if.slave                   in_link,
    li_link_if.master                  out_link,
`ifdef LI_RELAY_FIFO_STATS_EN
    output logic [31:0]                stall_cycles,
    output logic [$clog2(DEPTH):0]     max_occupancy,
`endif
    output logic                       overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] STOP_LEVEL = (AW+1)'(DEPTH - SKID);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next, count_after_pop;
    logic             out_valid_reg, in_stop_reg, overflow_err_reg;
    logic [WIDTH-1:0] out_data_reg, head_next;
    logic             push, pop, full;

    always_comb begin
        full            = (count_reg == FULL_COUNT);
        pop             = out_valid_reg & ~out_link.stop;
        push            = in_link.valid & (~full | pop);
        count_after_pop = count_reg - (AW+1)'(pop);
        count_next      = count_after_pop + (AW+1)'(push);
        rd_ptr_next     = rd_ptr_reg + AW'(pop);
        // When the buffer would otherwise be empty, the incoming token becomes the next head.
        head_next       = (count_after_pop == '0) ? in_link.data : mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_link.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            in_stop_reg      <= 1'b0;
            overflow_err_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            out_valid_reg <= (count_next != '0);
            if (count_next != '0) begin
                out_data_reg <= head_next;
            end
            in_stop_reg <= (count_next >= STOP_LEVEL);
            if (in_link.valid && !push) begin
                overflow_err_reg <= 1'b1;
            end
        end
    end

    assign out_link.valid = out_valid_reg;
    assign out_link.data  = out_data_reg;
    assign in_link.stop   = in_stop_reg;
    assign overflow_err   = overflow_err_reg;

`ifdef LI_RELAY_FIFO_STATS_EN
    logic [31:0] stall_cycles_reg;
    logic [AW:0] max_occupancy_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_reg  <= '0;
            max_occupancy_reg <= '0;
        end else begin
            if (out_valid_reg && out_link.stop && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (count_next > max_occupancy_reg) begin
                max_occupancy_reg <= count_next;
            end
        end
    end

    assign stall_cycles  = stall_cycles_reg;
    assign max_occupancy = max_occupancy_reg;
`endif
endmodule
